// File: rtl/branch_predict_unit_if.sv
// Prediction and resolve request/response bundle for branch_predict_unit.
// master drives requests; slave (the predictor) drives the registered results.
interface branch_predict_unit_if #(
    parameter int unsigned PC_W = 16
);
    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic            pred_out_valid;
    logic            pred_taken;

    logic            res_valid;
    logic [4:0]      res_opcode;
    logic [1:0]      res_flags;
    logic [PC_W-1:0] res_pc;
    logic            res_pred_taken;
    logic            res_out_valid;
    logic            pc_branch_sel_out;
    logic            mispredict;
    logic [15:0]     mispredict_cnt;

    modport master (
        output pred_valid, pred_pc,
        output res_valid, res_opcode, res_flags, res_pc, res_pred_taken,
        input  pred_out_valid, pred_taken,
        input  res_out_valid, pc_branch_sel_out, mispredict, mispredict_cnt
    );

    modport slave (
        input  pred_valid, pred_pc,
        input  res_valid, res_opcode, res_flags, res_pc, res_pred_taken,
        output pred_out_valid, pred_taken,
        output res_out_valid, pc_branch_sel_out, mispredict, mispredict_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: PC-indexed table of saturating counters, with a
// one-cycle prediction path and a one-cycle resolve/train path.
module branch_predict_unit #(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CTR_W = 2
) (
    input logic clk,
    input logic rst,
    branch_predict_unit_if.slave bus
);
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN  = '0;
    localparam logic [CTR_W-1:0] CTR_ONE  = 1;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};

    localparam logic [4:0] OP_BEQ = 5'b10011;
    localparam logic [4:0] OP_BNE = 5'b10110;
    localparam logic [4:0] OP_BLT = 5'b10100;
    localparam logic [4:0] OP_BGT = 5'b10101;
    localparam logic [4:0] OP_BAL = 5'b11000;

    logic [CTR_W-1:0] table_q [DEPTH];
    logic [CTR_W-1:0] table_d [DEPTH];

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             is_branch;
    logic             outcome;

    logic        pred_out_valid_q, pred_out_valid_d;
    logic        pred_taken_q, pred_taken_d;
    logic        res_out_valid_q, res_out_valid_d;
    logic        branch_sel_q, branch_sel_d;
    logic        mispredict_q, mispredict_d;
    logic [15:0] mis_cnt_q, mis_cnt_d;

    logic unused_pc_bits;

    assign pred_idx = bus.pred_pc[IDX_W-1:0];
    assign res_idx  = bus.res_pc[IDX_W-1:0];
    assign unused_pc_bits = ^{bus.pred_pc[PC_W-1:IDX_W], bus.res_pc[PC_W-1:IDX_W]};

    always_comb begin
        is_branch = 1'b1;
        outcome   = 1'b0;
        case (bus.res_opcode)
            OP_BEQ:  outcome = bus.res_flags[1];
            OP_BNE:  outcome = ~bus.res_flags[1];
            OP_BLT:  outcome = bus.res_flags[0];
            OP_BGT:  outcome = ~bus.res_flags[0];
            OP_BAL:  outcome = 1'b1;
            default: is_branch = 1'b0;
        endcase
    end

    always_comb begin
        table_d = table_q;
        if (bus.res_valid && is_branch) begin
            if (outcome && table_q[res_idx] != CTR_MAX) begin
                table_d[res_idx] = table_q[res_idx] + CTR_ONE;
            end else if (!outcome && table_q[res_idx] != CTR_MIN) begin
                table_d[res_idx] = table_q[res_idx] - CTR_ONE;
            end
        end
    end

    // Prediction reads table_q, so a same-cycle resolve to that index is not seen.
    always_comb begin
        pred_out_valid_d = bus.pred_valid;
        pred_taken_d     = bus.pred_valid & table_q[pred_idx][CTR_W-1];
        res_out_valid_d  = bus.res_valid;
        branch_sel_d     = bus.res_valid & outcome;
        mispredict_d     = bus.res_valid & (outcome ^ bus.res_pred_taken);
        mis_cnt_d        = mis_cnt_q;
        if (mispredict_d && mis_cnt_q != 16'hFFFF) begin
            mis_cnt_d = mis_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= 1'b0;
            res_out_valid_q  <= 1'b0;
            branch_sel_q     <= 1'b0;
            mispredict_q     <= 1'b0;
            mis_cnt_q        <= 16'd0;
            table_q          <= '{default: CTR_INIT};
        end else begin
            pred_out_valid_q <= pred_out_valid_d;
            pred_taken_q     <= pred_taken_d;
            res_out_valid_q  <= res_out_valid_d;
            branch_sel_q     <= branch_sel_d;
            mispredict_q     <= mispredict_d;
            mis_cnt_q        <= mis_cnt_d;
            table_q          <= table_d;
        end
    end

    assign bus.pred_out_valid    = pred_out_valid_q;
    assign bus.pred_taken        = pred_taken_q;
    assign bus.res_out_valid     = res_out_valid_q;
    assign bus.pc_branch_sel_out = branch_sel_q;
    assign bus.mispredict        = mispredict_q;
    assign bus.mispredict_cnt    = mis_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed + short random bench for branch_predict_unit; expected results are
// queued at drive time from a reference model and compared one cycle later.
module tb_branch_predict_unit;
    logic clk;
    logic rst;

    branch_predict_unit_if #(.PC_W(16)) bus ();

    branch_predict_unit #(.PC_W(16), .IDX_W(4), .CTR_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        pv;
        logic        pt;
        logic        rv;
        logic        sel;
        logic        mis;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  ref_tbl [16];
    logic [15:0] ref_cnt = 16'd0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // Returns {is_branch, taken}.
    function automatic logic [1:0] ref_decode(input logic [4:0] op, input logic [1:0] f);
        if (op == 5'b10011) return {1'b1, f[1]};
        if (op == 5'b10110) return {1'b1, !f[1]};
        if (op == 5'b10100) return {1'b1, f[0]};
        if (op == 5'b10101) return {1'b1, !f[0]};
        if (op == 5'b11000) return 2'b11;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input logic r, input logic pv, input logic [15:0] ppc,
                       input logic rv, input logic [4:0] op, input logic [1:0] fl,
                       input logic [15:0] rpc, input logic rpt, input string tag);
        exp_t       e;
        logic [1:0] d;
        logic [1:0] c;
        @(negedge clk);
        rst                = r;
        bus.pred_valid     = pv;
        bus.pred_pc        = ppc;
        bus.res_valid      = rv;
        bus.res_opcode     = op;
        bus.res_flags      = fl;
        bus.res_pc         = rpc;
        bus.res_pred_taken = rpt;
        e.tag = tag;
        if (r) begin
            e.pv = 1'b0; e.pt = 1'b0; e.rv = 1'b0; e.sel = 1'b0; e.mis = 1'b0;
            ref_cnt = 16'd0;
            foreach (ref_tbl[i]) ref_tbl[i] = 2'b01;
            e.cnt = ref_cnt;
        end else begin
            d     = ref_decode(op, fl);
            e.pv  = pv;
            e.pt  = pv && (ref_tbl[ppc[3:0]] >= 2'd2);
            e.rv  = rv;
            e.sel = rv && d[0];
            e.mis = rv && (d[0] != rpt);
            if (e.mis && ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
            e.cnt = ref_cnt;
            if (rv && d[1]) begin
                c = ref_tbl[rpc[3:0]];
                if (d[0]) ref_tbl[rpc[3:0]] = (c == 2'd3) ? c : c + 2'd1;
                else      ref_tbl[rpc[3:0]] = (c == 2'd0) ? c : c - 2'd1;
            end
        end
        sb.push_back(e);
    endtask

    task automatic idle(input string tag);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 5'h0, 2'b00, 16'h0, 1'b0, tag);
    endtask

    task automatic pred(input logic [15:0] pc, input string tag);
        cyc(1'b0, 1'b1, pc, 1'b0, 5'h0, 2'b00, 16'h0, 1'b0, tag);
    endtask

    task automatic res(input logic [4:0] op, input logic [1:0] fl, input logic [15:0] pc,
                       input logic rpt, input string tag);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, op, fl, pc, rpt, tag);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "/pred_out_valid"}, {15'd0, bus.pred_out_valid}, {15'd0, e.pv});
            chk({e.tag, "/pred_taken"}, {15'd0, bus.pred_taken}, {15'd0, e.pt});
            chk({e.tag, "/res_out_valid"}, {15'd0, bus.res_out_valid}, {15'd0, e.rv});
            chk({e.tag, "/pc_branch_sel_out"}, {15'd0, bus.pc_branch_sel_out}, {15'd0, e.sel});
            chk({e.tag, "/mispredict"}, {15'd0, bus.mispredict}, {15'd0, e.mis});
            chk({e.tag, "/mispredict_cnt"}, bus.mispredict_cnt, e.cnt);
        end
    end

    logic [4:0] ops [6] = '{5'b10011, 5'b10110, 5'b10100, 5'b10101, 5'b11000, 5'b00001};

    initial begin
        rst = 1'b1;
        bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.res_valid = 1'b0;
        bus.res_opcode = '0; bus.res_flags = '0; bus.res_pc = '0; bus.res_pred_taken = 1'b0;

        // Reset, including requests that must be discarded.
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 5'h0, 2'b00, 16'h0, 1'b0, "rst0");
        cyc(1'b1, 1'b1, 16'h0003, 1'b1, 5'b11000, 2'b00, 16'h0003, 1'b0, "rst_discard");

        pred(16'h0003, "pred_init");
        res(5'b10011, 2'b10, 16'h0003, 1'b0, "beq_1");
        res(5'b10011, 2'b10, 16'h0003, 1'b0, "beq_2");
        idle("idle_cnt2");
        pred(16'h0013, "pred_alias");

        // Full decode table: every branch opcode against every flag value.
        for (int o = 0; o < 5; o++) begin
            for (int f = 0; f < 4; f++) begin
                res(ops[o], 2'(f), 16'h0008 + 16'(o), 1'(f), $sformatf("dec_op%0d_f%0d", o, f));
            end
        end

        // Saturation at index 7.
        for (int k = 0; k < 5; k++) res(5'b10011, 2'b10, 16'h0007, 1'b1, "sat_up");
        settle();
        chk("sat_ctr_max", {14'd0, dut.table_q[7]}, 16'd3);
        pred(16'h0007, "sat_pred_hi");
        res(5'b10011, 2'b00, 16'h0007, 1'b1, "sat_dn1");
        pred(16'h0007, "sat_pred_still_hi");
        for (int k = 0; k < 3; k++) res(5'b10011, 2'b00, 16'h0007, 1'b1, "sat_dn");
        res(5'b10011, 2'b00, 16'h0007, 1'b0, "sat_dn_floor");
        pred(16'h0007, "sat_pred_lo");
        settle();
        chk("sat_ctr_min", {14'd0, dut.table_q[7]}, 16'd0);

        // Same-cycle predict and resolve to index 5: prediction sees old value.
        cyc(1'b0, 1'b1, 16'h0005, 1'b1, 5'b10011, 2'b10, 16'h0015, 1'b0, "rbw_same");
        pred(16'h0005, "rbw_next");

        // Non-branch opcode: outcome 0, no table update.
        res(5'b00001, 2'b11, 16'h0005, 1'b1, "nonbranch");
        settle();
        chk("nonbranch_tbl", {14'd0, dut.table_q[5]}, 16'd2);
        pred(16'h0005, "nonbranch_pred");

        // Both paths busy every cycle.
        for (int k = 0; k < 30; k++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                ops[$urandom_range(0, 5)], 2'($urandom_range(0, 3)), 16'($urandom),
                1'($urandom_range(0, 1)), "rand");
        end

        // Reset mid-stream.
        cyc(1'b0, 1'b1, 16'h0007, 1'b1, 5'b11000, 2'b00, 16'h0007, 1'b0, "pre_rst");
        cyc(1'b1, 1'b1, 16'h0007, 1'b1, 5'b11000, 2'b00, 16'h0007, 1'b0, "mid_rst");
        settle();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rst_tbl%0d", i), {14'd0, dut.table_q[i]}, 16'd1);
        end
        idle("post_rst");
        pred(16'h0007, "post_rst_pred");
        idle("tail0");
        idle("tail1");
        settle();
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 16, meaning PC width in bits.
REQ-002 The block SHALL have parameter IDX_W, default 4, meaning predictor table index width (DEPTH = 2^IDX_W entries).
REQ-003 The block SHALL have parameter CTR_W, default 2, meaning saturating-counter width per entry (CTR_W >= 2).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock (all logic on rising edge).
REQ-005 The block SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-006 The block SHALL have port pred_valid, input, 1, meaning a prediction request is present this cycle.
REQ-007 The block SHALL have port pred_pc, input, PC_W, meaning the PC of the fetched instruction.
REQ-008 The block SHALL have port pred_out_valid, output, 1, meaning pred_taken is valid.
REQ-009 The block SHALL have port pred_taken, output, 1, meaning predicted direction (1 = taken).
REQ-010 The block SHALL have port res_valid, input, 1, meaning a resolve request is present this cycle.
REQ-011 The block SHALL have port res_opcode, input, 5, meaning the resolving instruction's opcode.
REQ-012 The block SHALL have port res_flags, input, 2, meaning ALU flags: [1] = Z (equal), [0] = N (less than).
REQ-013 The block SHALL have port res_pc, input, PC_W, meaning the PC of the resolving instruction.
REQ-014 The block SHALL have port res_pred_taken, input, 1, meaning the direction predicted earlier for that instruction.
REQ-015 The block SHALL have port res_out_valid, output, 1, meaning the resolve outputs are valid.
REQ-016 The block SHALL have port pc_branch_sel_out, output, 1, meaning the actual branch outcome (1 = take target).
REQ-017 The block SHALL have port mispredict, output, 1, meaning the actual outcome differs from res_pred_taken.
REQ-018 The block SHALL have port mispredict_cnt, output, 16, meaning a saturating count of mispredicts.

Function
REQ-019 Condition decode SHALL be: BEQ 10011 -> Z; BNE 10110 -> !Z; BLT 10100 -> N; BGT 10101 -> !N; BAL 11000 -> 1; any other opcode is non-branch, with outcome 0.
REQ-020 Table index SHALL be pc[IDX_W-1:0]; the table SHALL hold DEPTH counters of CTR_W bits each.
REQ-021 Prediction SHALL have 1-cycle latency: pred_valid at edge N gives pred_out_valid=1 and pred_taken = counter MSB after edge N; pred_out_valid SHALL be 0 in cycles with no request.
REQ-022 Resolve SHALL have 1-cycle latency: res_valid at edge N gives res_out_valid=1, pc_branch_sel_out = outcome, and mispredict = outcome XOR res_pred_taken after edge N.
REQ-023 On a resolve of a branch opcode, the indexed counter SHALL saturate-increment when taken and saturate-decrement when not taken (saturation points 2^CTR_W-1 and 0).
REQ-024 A non-branch resolve SHALL NOT update the table; mispredict SHALL equal res_pred_taken.
REQ-025 When a prediction and a resolve hit the same index in the same cycle, the prediction SHALL use the pre-update counter value (read-before-write, no bypass).
REQ-026 mispredict_cnt SHALL increment by 1 on each cycle where mispredict is registered as 1, and SHALL saturate at 16'hFFFF.
REQ-027 pc_branch_sel_out and mispredict SHALL be 0 whenever res_out_valid is 0.
REQ-028 Prediction and resolve paths SHALL be independent and fully pipelined, accepting one request each per cycle with no stalls.

Reset
REQ-029 While rst=1 at a clock edge, all outputs and mispredict_cnt SHALL become 0.
REQ-030 While rst=1 at a clock edge, every counter SHALL become weakly-not-taken, 2^(CTR_W-1)-1 (01 for CTR_W=2).
REQ-031 Requests presented in the cycle rst=1 SHALL be discarded; reset asserted mid-operation SHALL discard in-flight results, so the outputs are 0 on the following cycle.

Verification
REQ-032 The bench SHALL cover: reset, then pred pc=0x0003 -> one cycle later pred_out_valid=1, pred_taken=0.
REQ-033 The bench SHALL cover: resolve BEQ, flags=10, pc=0x0003, res_pred_taken=0 twice -> pc_branch_sel_out=1, mispredict=1 each time, mispredict_cnt=2; then pred pc=0x0013 (same index) -> pred_taken=1.
REQ-034 The bench SHALL cover the full decode table: BNE/BLT/BGT/BAL with all four flag values -> outcomes per REQ-019 (e.g. BGT flags=10 -> 1, BLT flags=10 -> 0).
REQ-035 The bench SHALL cover saturation: five taken resolves at one index -> counter=3; one not-taken resolve -> pred_taken stays 1; three more not-taken resolves -> counter=0, pred_taken=0.
REQ-036 The bench SHALL cover same-cycle pred and resolve to index 5 with counter=01 and taken -> pred_taken=0 this time, and 1 on the next prediction.
REQ-037 The bench SHALL cover opcode 00001 with res_pred_taken=1 -> pc_branch_sel_out=0, mispredict=1, table unchanged; and rst asserted mid-stream -> all outputs 0 and counters back to 01.
